// File: rtl/periph_bridge.sv
// periph_bridge: CPU-side decoder routing loads/stores to data memory,
// word-only peripheral slots and an interrupt pending/ack register.
module periph_bridge #(
    parameter int                   N_SLOT     = 2,
    parameter int                   N_EXT      = 1,
    parameter logic [32*N_SLOT-1:0] SLOT_BASE  = {32'h0000_7F10, 32'h0000_7F00},
    parameter logic [32*N_SLOT-1:0] SLOT_LIMIT = {32'h0000_7F1B, 32'h0000_7F0B},
    parameter logic [31:0]          ACK_ADDR   = 32'h0000_7F20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [3:0]             cpu_byteen,
    input  logic                   cpu_rd,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_fault,
    output logic [31:0]            dm_addr,
    output logic [31:0]            dm_wdata,
    output logic [3:0]             dm_byteen,
    input  logic [31:0]            dm_rdata,
    output logic [31:0]            slot_addr,
    output logic [31:0]            slot_wdata,
    output logic [N_SLOT-1:0]      slot_we,
    input  logic [32*N_SLOT-1:0]   slot_rdata,
    input  logic [N_SLOT-1:0]      slot_irq,
    input  logic [N_EXT-1:0]       ext_irq,
    output logic [5:0]             hw_int,
    output logic [31:0]            fault_addr,
    output logic [7:0]             fault_cnt
);

    typedef enum logic [1:0] {
        RS_DM,
        RS_SLOT,
        RS_ACK,
        RS_INV
    } rsel_e;

    rsel_e            r_rsel;
    logic [2:0]       r_ridx;
    logic [N_EXT-1:0] r_pend;
    logic [N_EXT-1:0] r_ext_prev;
    logic [31:0]      r_fault_addr;
    logic [7:0]       r_fault_cnt;

    logic             w_slot_hit;
    logic [2:0]       w_slot_idx;
    logic             w_ack_hit;
    logic             w_dm_sel;
    logic             w_be_ok;
    logic             w_full;
    logic             w_fault;
    logic             w_ack_wr;
    logic [N_EXT-1:0] w_edge;
    logic [N_EXT-1:0] w_clr;
    logic [N_EXT-1:0] w_pend_nxt;
    rsel_e            w_rsel_nxt;

    // Scan high-to-low so the lowest hitting slot is the last writer.
    always_comb begin
        w_slot_hit = 1'b0;
        w_slot_idx = 3'd0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (cpu_addr >= SLOT_BASE[32*i +: 32] &&
                cpu_addr <= SLOT_LIMIT[32*i +: 32]) begin
                w_slot_hit = 1'b1;
                w_slot_idx = 3'(i);
            end
        end
    end

    assign w_ack_hit = (cpu_addr == ACK_ADDR);
    assign w_dm_sel  = !w_slot_hit && !w_ack_hit;
    assign w_full    = (cpu_byteen == 4'hF);
    assign w_be_ok   = (cpu_byteen == 4'h0) || w_full;
    assign w_fault   = (w_slot_hit || w_ack_hit) &&
                       ((cpu_addr[1:0] != 2'b00) || !w_be_ok);

    assign cpu_fault  = w_fault;
    assign dm_addr    = cpu_addr;
    assign dm_wdata   = cpu_wdata;
    assign slot_addr  = cpu_addr;
    assign slot_wdata = cpu_wdata;
    assign dm_byteen  = w_dm_sel ? cpu_byteen : 4'h0;

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            slot_we[i] = w_slot_hit && w_full && !w_fault &&
                         (w_slot_idx == 3'(i));
        end
    end

    // A new edge on a bit wins over a same-cycle ack of that bit.
    assign w_ack_wr   = w_ack_hit && w_full && !w_fault;
    assign w_edge     = ext_irq & ~r_ext_prev;
    assign w_clr      = w_ack_wr ? cpu_wdata[N_EXT-1:0] : '0;
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

    always_comb begin
        w_rsel_nxt = RS_DM;
        if (w_fault) begin
            w_rsel_nxt = RS_INV;
        end else if (w_slot_hit) begin
            w_rsel_nxt = RS_SLOT;
        end else if (w_ack_hit) begin
            w_rsel_nxt = RS_ACK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsel       <= RS_DM;
            r_ridx       <= 3'd0;
            r_pend       <= '0;
            r_ext_prev   <= '0;
            r_fault_addr <= 32'h0;
            r_fault_cnt  <= 8'h0;
        end else begin
            r_ext_prev <= ext_irq;
            r_pend     <= w_pend_nxt;
            if (cpu_rd) begin
                r_rsel <= w_rsel_nxt;
                r_ridx <= w_slot_idx;
            end
            if (w_fault) begin
                r_fault_addr <= cpu_addr;
                if (r_fault_cnt != 8'hFF) begin
                    r_fault_cnt <= r_fault_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        cpu_rdata = 32'h0;
        case (r_rsel)
            RS_DM: cpu_rdata = dm_rdata;
            RS_SLOT: begin
                for (int i = 0; i < N_SLOT; i++) begin
                    if (r_ridx == 3'(i)) begin
                        cpu_rdata = slot_rdata[32*i +: 32];
                    end
                end
            end
            RS_ACK: cpu_rdata[N_EXT-1:0] = r_pend;
            default: cpu_rdata = 32'h0;
        endcase
    end

    always_comb begin
        hw_int = 6'h0;
        hw_int[N_SLOT-1:0]     = slot_irq;
        hw_int[N_SLOT +: N_EXT] = r_pend;
    end

    assign fault_addr = r_fault_addr;
    assign fault_cnt  = r_fault_cnt;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed and random checks of periph_bridge
// against a behavioural model of the decode, read and interrupt rules.
module tb_periph_bridge;

    localparam int          NS  = 2;
    localparam logic [31:0] ACK = 32'h0000_7F20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata;
    logic [31:0] slot_addr;
    logic [31:0] slot_wdata;
    logic [1:0]  slot_we;
    logic [63:0] slot_rdata;
    logic [1:0]  slot_irq;
    logic [0:0]  ext_irq;
    logic [5:0]  hw_int;
    logic [31:0] fault_addr;
    logic [7:0]  fault_cnt;

    periph_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_fault  (cpu_fault),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_byteen  (dm_byteen),
        .dm_rdata   (dm_rdata),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .slot_we    (slot_we),
        .slot_rdata (slot_rdata),
        .slot_irq   (slot_irq),
        .ext_irq    (ext_irq),
        .hw_int     (hw_int),
        .fault_addr (fault_addr),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] mb [NS] = '{32'h7F00, 32'h7F10};
    logic [31:0] ml [NS] = '{32'h7F0B, 32'h7F1B};

    // Model read selector: -1 DM, -2 ACK register, -3 invalid, else slot.
    int          m_rsel;
    logic        m_pend;
    logic        m_prev;
    logic [31:0] m_faddr;
    int          m_fcnt;

    function automatic int slot_of(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= mb[i] && a <= ml[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit is_fault(input logic [31:0] a,
                                    input logic [3:0] be);
        bit periph;
        periph = (slot_of(a) >= 0) || (a == ACK);
        return periph && ((a[1:0] != 2'b00) || !(be == 4'h0 || be == 4'hF));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t",
                     nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic compare_all();
        int          s;
        bit          f;
        logic [31:0] e_rd;
        logic [31:0] e_we;
        s = slot_of(cpu_addr);
        f = is_fault(cpu_addr, cpu_byteen);
        e_we = (s >= 0 && cpu_byteen == 4'hF && !f) ? (32'd1 << s) : 32'd0;
        if (m_rsel == -1) e_rd = dm_rdata;
        else if (m_rsel == -2) e_rd = {31'd0, m_pend};
        else if (m_rsel == -3) e_rd = 32'd0;
        else e_rd = slot_rdata[m_rsel*32 +: 32];
        chk("dm_addr", dm_addr, cpu_addr);
        chk("slot_addr", slot_addr, cpu_addr);
        chk("dm_wdata", dm_wdata, cpu_wdata);
        chk("slot_wdata", slot_wdata, cpu_wdata);
        chk("cpu_fault", {31'd0, cpu_fault}, {31'd0, f});
        chk("dm_byteen", {28'd0, dm_byteen},
            (s < 0 && cpu_addr != ACK) ? {28'd0, cpu_byteen} : 32'd0);
        chk("slot_we", {30'd0, slot_we}, e_we);
        chk("hw_int", {26'd0, hw_int},
            ({31'd0, m_pend} << NS) | {30'd0, slot_irq});
        chk("fault_addr", fault_addr, m_faddr);
        chk("fault_cnt", {24'd0, fault_cnt}, 32'(m_fcnt));
        chk("cpu_rdata", cpu_rdata, e_rd);
    endtask

    task automatic model_tick();
        int   s;
        bit   f;
        logic edge_b;
        @(posedge clk);
        s = slot_of(cpu_addr);
        f = is_fault(cpu_addr, cpu_byteen);
        if (reset) begin
            m_rsel  = -1;
            m_pend  = 1'b0;
            m_prev  = 1'b0;
            m_faddr = 32'd0;
            m_fcnt  = 0;
        end else begin
            edge_b = ext_irq[0] && !m_prev;
            m_prev = ext_irq[0];
            if (cpu_addr == ACK && cpu_byteen == 4'hF && !f && cpu_wdata[0])
                m_pend = 1'b0;
            if (edge_b) m_pend = 1'b1;
            if (cpu_rd) begin
                if (f) m_rsel = -3;
                else if (s >= 0) m_rsel = s;
                else if (cpu_addr == ACK) m_rsel = -2;
                else m_rsel = -1;
            end
            if (f) begin
                m_faddr = cpu_addr;
                if (m_fcnt < 255) m_fcnt++;
            end
        end
    endtask

    task automatic set_in(input logic [31:0] a,
                          input logic [3:0]  be  = 4'h0,
                          input logic        rd  = 1'b0,
                          input logic [31:0] wd  = 32'h0,
                          input logic        ext = 1'b0,
                          input logic        rst = 1'b0,
                          input logic [31:0] dmr = 32'h0,
                          input logic [31:0] s1r = 32'h0);
        @(negedge clk);
        reset      = rst;
        cpu_addr   = a;
        cpu_byteen = be;
        cpu_rd     = rd;
        cpu_wdata  = wd;
        ext_irq    = ext;
        dm_rdata   = dmr;
        slot_rdata = {s1r, 32'h0};
        slot_irq   = 2'b00;
        #1;
        compare_all();
    endtask

    logic [31:0] edge_list [7] = '{32'h7EFF, 32'h7F0C, 32'h7F0F,
                                   32'h7F1C, 32'h7F1F, 32'h7F21, 32'h7F24};

    initial begin
        reset      = 1'b1;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_byteen = 4'h0;
        cpu_rd     = 1'b0;
        dm_rdata   = 32'h0;
        slot_rdata = 64'h0;
        slot_irq   = 2'b00;
        ext_irq    = 1'b0;
        model_tick();

        // Store to slot 0, then a byte store that must fault.
        set_in(32'h7F04, 4'hF, 1'b0, 32'h1234);
        chk("v1_slot_we", {30'd0, slot_we}, 32'h1);
        chk("v1_dm_byteen", {28'd0, dm_byteen}, 32'h0);
        chk("v1_fault", {31'd0, cpu_fault}, 32'h0);
        model_tick();
        set_in(32'h7F05, 4'b0010);
        chk("v2_fault", {31'd0, cpu_fault}, 32'h1);
        chk("v2_slot_we", {30'd0, slot_we}, 32'h0);
        model_tick();
        set_in(32'h100);
        chk("v2_faddr", fault_addr, 32'h7F05);
        chk("v2_fcnt", {24'd0, fault_cnt}, 32'h1);
        model_tick();

        // Loads from slot 1 and from data memory.
        set_in(32'h7F14, 4'h0, 1'b1);
        model_tick();
        set_in(32'h100, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'hCAFE);
        chk("v3_slot_rd", cpu_rdata, 32'hCAFE);
        model_tick();
        set_in(32'h200, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBEEF);
        chk("v3_dm_rd", cpu_rdata, 32'hBEEF);
        model_tick();

        // External edge, hold, ack, and ack racing a fresh edge.
        set_in(32'h200, 4'h0, 1'b0, 32'h0, 1'b1);
        model_tick();
        set_in(32'h200);
        chk("v4_set", {26'd0, hw_int}, 32'h4);
        model_tick();
        set_in(32'h200);
        chk("v4_hold", {26'd0, hw_int}, 32'h4);
        model_tick();
        set_in(ACK, 4'hF, 1'b0, 32'h1);
        model_tick();
        set_in(32'h200);
        chk("v4_ack", {26'd0, hw_int}, 32'h0);
        model_tick();
        set_in(32'h200, 4'h0, 1'b0, 32'h0, 1'b1);
        model_tick();
        set_in(32'h200);
        model_tick();
        set_in(ACK, 4'hF, 1'b0, 32'h1, 1'b1);
        model_tick();
        set_in(32'h200);
        chk("v4_race", {26'd0, hw_int}, 32'h4);
        model_tick();

        // Fault counter saturation.
        for (int i = 0; i < 300; i++) begin
            set_in(32'h7F01);
            model_tick();
        end
        set_in(32'h200);
        chk("v5_sat", {24'd0, fault_cnt}, 32'hFF);
        model_tick();

        // Reset during an ack write with pending set and ACK selected.
        set_in(ACK, 4'h0, 1'b1);
        model_tick();
        set_in(32'h200);
        chk("v6_ack_rd", cpu_rdata, 32'h1);
        model_tick();
        set_in(ACK, 4'hF, 1'b0, 32'h1, 1'b1, 1'b1);
        model_tick();
        set_in(32'h300, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h55);
        chk("v6_pend", {26'd0, hw_int}, 32'h0);
        chk("v6_rsel", cpu_rdata, 32'h55);
        chk("v6_fcnt", {24'd0, fault_cnt}, 32'h0);
        model_tick();
        set_in(32'h300, 4'h0, 1'b0, 32'h0, 1'b1);
        chk("v6_post_edge", {26'd0, hw_int}, 32'h4);
        model_tick();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 5))
                0: cpu_addr = $urandom;
                1: cpu_addr = 32'h7F00 + $urandom_range(0, 11);
                2: cpu_addr = 32'h7F10 + $urandom_range(0, 11);
                3: cpu_addr = ACK;
                4: cpu_addr = edge_list[$urandom_range(0, 6)];
                default: cpu_addr = (32'h7F00 + ($urandom_range(0, 1) << 4))
                                    + ($urandom_range(0, 2) << 2);
            endcase
            case ($urandom_range(0, 2))
                0: cpu_byteen = 4'h0;
                1: cpu_byteen = 4'hF;
                default: cpu_byteen = 4'($urandom);
            endcase
            cpu_rd     = $urandom_range(0, 1) == 1;
            cpu_wdata  = $urandom;
            if ($urandom_range(0, 3) == 0) ext_irq = ~ext_irq;
            slot_irq   = 2'($urandom);
            dm_rdata   = $urandom;
            slot_rdata = {$urandom, $urandom};
            #1;
            compare_all();
            model_tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter N_SLOT, default 2, number of word-only peripheral slots (1..5).
REQ-002 SHALL have parameter N_EXT, default 1, number of external interrupt lines; N_SLOT+N_EXT SHALL be <= 6.
REQ-003 SHALL have parameter SLOT_BASE, default {32'h0000_7F10,32'h0000_7F00}, packed 32-bit inclusive base per slot, slot 0 in LSBs.
REQ-004 SHALL have parameter SLOT_LIMIT, default {32'h0000_7F1B,32'h0000_7F0B}, packed 32-bit inclusive limit per slot.
REQ-005 SHALL have parameter ACK_ADDR, default 32'h0000_7F20, interrupt pending/ack register address.
REQ-006 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-007 Ports, in order (name  direction  width  meaning):
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 cpu_addr  in  32  CPU byte address
 cpu_wdata  in  32  CPU store data
 cpu_byteen  in  4  store byte enables; 0000 means no write
 cpu_rd  in  1  load request this cycle
 cpu_rdata  out  32  load data, valid the cycle after cpu_rd
 cpu_fault  out  1  access fault this cycle
 dm_addr  out  32  data-memory address
 dm_wdata  out  32  data-memory store data
 dm_byteen  out  4  data-memory byte enables
 dm_rdata  in  32  data-memory read data (1-cycle latency)
 slot_addr  out  32  shared slot address
 slot_wdata  out  32  shared slot store data
 slot_we  out  N_SLOT  per-slot write enable
 slot_rdata  in  32*N_SLOT  per-slot read data (1-cycle latency)
 slot_irq  in  N_SLOT  per-slot level interrupt
 ext_irq  in  N_EXT  external interrupt lines
 hw_int  out  6  interrupt vector to CP0
 fault_addr  out  32  address of most recent fault
 fault_cnt  out  8  saturating fault counter

Function
REQ-008 Decode: slot i hit when SLOT_BASE[i] <= cpu_addr <= SLOT_LIMIT[i]; lowest hitting index SHALL win on overlap; ACK hit when cpu_addr == ACK_ADDR; no hit SHALL select DM.
REQ-009 dm_addr, slot_addr SHALL equal cpu_addr; dm_wdata, slot_wdata SHALL equal cpu_wdata, combinationally.
REQ-010 Fault SHALL be: (slot or ACK hit) and (cpu_addr[1:0] != 0 or cpu_byteen not in {0000,1111}); cpu_fault combinational, same cycle.
REQ-011 slot_we[i] SHALL be 1 only for the winning slot with cpu_byteen==1111 and no fault.
REQ-012 dm_byteen SHALL be cpu_byteen when DM selected, else 0000; a faulted access SHALL never write anything.
REQ-013 Read path: on cpu_rd, register rsel_q <= {DM, slot i, ACK}; cpu_rdata next cycle SHALL be dm_rdata, slot_rdata[i], or pending zero-extended, per rsel_q; faulted read SHALL set rsel_q to ACK-invalid and return 0.
REQ-014 Without cpu_rd, rsel_q SHALL hold; cpu_rdata follows rsel_q continuously.
REQ-015 Ext edge: ext_prev <= ext_irq each cycle; rising edge (ext_irq & ~ext_prev) SHALL set pending bit.
REQ-016 Write of 1111 to ACK_ADDR without fault SHALL clear pending bits where cpu_wdata bit is 1; same-cycle new edge on a bit SHALL win (bit stays 1).
REQ-017 hw_int SHALL be {zeros, pending[N_EXT-1:0], slot_irq[N_SLOT-1:0]}, slot 0 at bit 0, combinational from registers/inputs.
REQ-018 On each fault cycle, fault_addr <= cpu_addr and fault_cnt <= fault_cnt+1, saturating at 8'hFF.

Reset
REQ-019 On reset: rsel_q=DM, pending=0, ext_prev=0, fault_addr=0, fault_cnt=0; cpu_rdata then equals dm_rdata.
REQ-020 Reset SHALL dominate all same-cycle events (edges, ack writes, faults); an ext_irq high in the first post-reset cycle SHALL register as an edge.

Verification
V1 sw 0x1234 to 0x7F04 byteen 1111 -> slot_we=01, dm_byteen=0000, cpu_fault=0.
V2 sb to 0x7F05 byteen 0010 -> cpu_fault=1, slot_we=00, fault_addr=0x7F05, fault_cnt=1 next cycle.
V3 lw 0x7F14 cpu_rd=1, slot_rdata[1]=0xCAFE next cycle -> cpu_rdata=0xCAFE one cycle after request; lw 0x100 -> dm_rdata.
V4 ext_irq 0->1 -> hw_int[2]=1 next cycle and held after ext_irq drops; sw 0x1 to 0x7F20 -> hw_int[2]=0; ack with simultaneous edge -> stays 1.
V5 300 consecutive faults -> fault_cnt=8'hFF, no wrap.
V6 reset asserted during ack write and pending=1 -> pending=0, rsel_q=DM, fault_cnt=0.
